// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_mult_dp.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator/multiplier
// shift register, W+1-bit adder and final sign fix-up into the product register.
module shift_mult_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    output logic [2*WIDTH-1:0]   prod
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q,  mult_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic               sign_q,  sign_d;
    logic [2*WIDTH-1:0] out_q,   out_d;
    logic [WIDTH:0]     sum;

    // Magnitude of a W-bit operand; -2^(W-1) maps onto itself, which reads correctly as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic is_tc, input logic [WIDTH-1:0] v);
        return (is_tc && v[WIDTH-1]) ? -v : v;
    endfunction

    // Apply the result sign to the unsigned product, modulo 2^(2W).
    function automatic logic [2*WIDTH-1:0] fix_sign(input logic neg, input logic [2*WIDTH-1:0] p);
        return neg ? -p : p;
    endfunction

    // Next-state logic: capture on load, one add-and-shift per step, sign fix-up on finish.
    always_comb begin
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        out_d   = out_q;
        sum     = mult_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        if (load) begin
            mcand_d = magnitude(tc, ina);
            mult_d  = magnitude(tc, inb);
            acc_d   = '0;
            sign_d  = tc & (ina[WIDTH-1] ^ inb[WIDTH-1]);
        end else if (step) begin
            acc_d  = sum[WIDTH:1];
            mult_d = {sum[0], mult_q[WIDTH-1:1]};
        end
        if (finish) begin
            out_d = fix_sign(sign_q, {acc_q, mult_q});
        end
    end

    // Datapath registers; clear wipes everything including the visible product.
    always_ff @(posedge clk) begin
        if (clr) begin
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
        end
    end

    assign prod = out_q;

endmodule

// File: rtl/shift_mult_n.sv
// Sequential shift-add multiplier top: start/busy/done handshake, step counter and FSM.
// RUN performs WIDTH add-shift steps and one fix-up cycle, so a start accepted at
// edge k raises done after edge k+WIDTH+1; done is a single-cycle DONE state.
module shift_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 sig,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            load;
    logic            step;
    logic            finish;

    // Next-state and datapath strobes; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(WIDTH);
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (sig) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    shift_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .clr    (sig),
        .load   (load),
        .step   (step),
        .finish (finish),
        .tc     (tc),
        .ina    (ina),
        .inb    (inb),
        .prod   (out)
    );

endmodule

// File: tb/tb_shift_mult_n.sv
// Self-checking bench for shift_mult_n at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_shift_mult_n;

    logic        clk = 1'b0;
    logic        sig = 1'b1;

    logic        start8 = 1'b0, tc8 = 1'b0;
    logic [7:0]  ina8 = '0, inb8 = '0;
    logic        busy8, done8;
    logic [15:0] out8;

    logic        start16 = 1'b0, tc16 = 1'b0;
    logic [15:0] ina16 = '0, inb16 = '0;
    logic        busy16, done16;
    logic [31:0] out16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_mult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .sig(sig), .start(start8), .tc(tc8), .ina(ina8), .inb(inb8),
        .busy(busy8), .done(done8), .out(out8)
    );

    shift_mult_n #(.WIDTH(16)) dut16 (
        .clk(clk), .sig(sig), .start(start16), .tc(tc16), .ina(ina16), .inb(inb16),
        .busy(busy16), .done(done16), .out(out16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer product of the operands read as signed or unsigned, truncated to 2w bits.
    function automatic logic [63:0] model(input int w, input bit t, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, p;
        longint unsigned mask;
        sa = longint'(a);
        sb = longint'(b);
        if (t && a[w-1]) sa = sa - (longint'(1) << w);
        if (t && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p) & 64'(mask);
    endfunction

    // One WIDTH=8 operation; poke>=0 re-asserts start with new operands that many edges into RUN.
    task automatic op8(input string tag, input bit t, input logic [7:0] a, input logic [7:0] b, input int poke);
        logic [63:0] exp;
        int n;
        exp = model(8, t, 64'(a), 64'(b));
        @(negedge clk);
        start8 = 1'b1; tc8 = t; ina8 = a; inb8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; tc8 = ~t; ina8 = 8'($urandom); inb8 = 8'($urandom);
        chk({tag, "_busy"}, 64'(busy8), 64'(1));
        n = 0;
        while (!done8 && n < 40) begin
            start8 = (n == poke);
            if (n == poke) begin ina8 = 8'($urandom); inb8 = 8'($urandom); end
            @(posedge clk); #1;
            n++;
            if (!done8) chk({tag, "_busy_run"}, 64'(busy8), 64'(1));
        end
        start8 = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(9));
        chk({tag, "_out"}, 64'(out8), exp);
        chk({tag, "_excl"}, 64'(busy8), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(done8), 64'(0));
        chk({tag, "_hold"}, 64'(out8), exp);
    endtask

    task automatic op16(input string tag, input bit t, input logic [15:0] a, input logic [15:0] b);
        logic [63:0] exp;
        int n;
        exp = model(16, t, 64'(a), 64'(b));
        @(negedge clk);
        start16 = 1'b1; tc16 = t; ina16 = a; inb16 = b;
        @(posedge clk); #1;
        start16 = 1'b0; ina16 = 16'($urandom); inb16 = 16'($urandom);
        n = 0;
        while (!done16 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(17));
        chk({tag, "_out"}, 64'(out16), exp);
    endtask

    initial begin
        int cyc, prev, cnt, seen;
        logic [63:0] exp;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", 64'(busy8), 64'(0));
        chk("rst_done8", 64'(done8), 64'(0));
        chk("rst_out8", 64'(out8), 64'(0));
        chk("rst_out16", 64'(out16), 64'(0));
        sig = 1'b0;

        op8("uu_max", 1'b0, 8'hFF, 8'hFF, -1);
        chk("uu_max_lit", 64'(out8), 64'h0000_FE01);
        op8("ss_min", 1'b1, 8'h80, 8'h80, -1);
        chk("ss_min_lit", 64'(out8), 64'h0000_4000);
        op8("ss_neg", 1'b1, 8'hFD, 8'h05, -1);
        chk("ss_neg_lit", 64'(out8), 64'h0000_FFF1);
        op8("uu_fd", 1'b0, 8'hFD, 8'h05, -1);
        chk("uu_fd_lit", 64'(out8), 64'h0000_04F1);
        op8("zero", 1'b1, 8'h00, 8'h80, -1);
        op8("ignore", 1'b0, 8'h37, 8'hC9, 3);

        for (int i = 0; i < 24; i++) begin
            op8("rand8", 1'($urandom), 8'($urandom), 8'($urandom), -1);
        end

        // Abort mid-operation with a reset pulse.
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b0; ina8 = 8'hAB; inb8 = 8'hCD;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sig = 1'b1;
        @(posedge clk); #1;
        sig = 1'b0;
        chk("abort_busy", 64'(busy8), 64'(0));
        chk("abort_done", 64'(done8), 64'(0));
        chk("abort_out", 64'(out8), 64'(0));
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        chk("abort_nodone", 64'(seen), 64'(0));
        op8("post_abort", 1'b1, 8'h7F, 8'h81, -1);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        exp = model(8, 1'b1, 64'h9C, 64'h37);
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b1; ina8 = 8'h9C; inb8 = 8'h37;
        cyc = 0; prev = -1; cnt = 0;
        while (cnt < 3 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) begin
                chk("b2b_out", 64'(out8), exp);
                chk("b2b_excl", 64'(busy8), 64'(0));
                if (prev >= 0) chk("b2b_period", 64'(cyc - prev), 64'(10));
                prev = cyc;
                cnt++;
            end
        end
        chk("b2b_count", 64'(cnt), 64'(3));
        @(posedge clk); #1;
        chk("b2b_restart_busy", 64'(busy8), 64'(1));
        chk("b2b_restart_done", 64'(done8), 64'(0));
        start8 = 1'b0;
        repeat (12) @(posedge clk);

        op16("w16_umax", 1'b0, 16'hFFFF, 16'hFFFF);
        chk("w16_umax_lit", 64'(out16), 64'h0000_0000_FFFE_0001);
        op16("w16_smix", 1'b1, 16'h8000, 16'h7FFF);
        chk("w16_smix_lit", 64'(out16), 64'h0000_0000_C000_8000);
        for (int i = 0; i < 8; i++) begin
            op16("rand16", 1'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
